carry_skip_adder_pipe: RTL and testbench

Parametrised, pipelined carry-skip (carry-bypass) adder. Splits a WIDTH-bit add into BLOCK-bit skip groups, evaluates GPS groups per pipeline stage, and moves operands and partial sums through a valid/ready pipeline, one result per cycle at full throughput. This is the datapath-width successor to the team's fixed 4-bit bypass adder, used wherever wide adds must meet clock without a full carry-lookahead tree.

---
 rtl/csa_pkg.sv | 17 +
 rtl/carry_skip_adder_pipe_if.sv | 31 +++
 rtl/carry_skip_group.sv | 24 ++
 rtl/carry_skip_adder_pipe.sv | 118 +++++++++++
 tb/tb_carry_skip_adder_pipe.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-skip adder.
package csa_pkg;

  typedef struct packed {
    logic vld;
    logic cy;
  } stage_ctl_t;

  function automatic int csa_stages(input int width, input int block, input int gps);
    return ((width / block) + gps - 1) / gps;
  endfunction

  function automatic bit csa_params_ok(input int width, input int block, input int gps);
    return (block >= 1) && (gps >= 1) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/carry_skip_adder_pipe_if.sv
// Operand/result valid-ready bundle for carry_skip_adder_pipe.
// The sub signal exists only when CSA_SUB_EN is defined.
interface carry_skip_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CSA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef CSA_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/carry_skip_group.sv
// One BLOCK-bit ripple group with a propagate-driven bypass of its carry.
module carry_skip_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign p    = a ^ b;
  assign c[0] = ci;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    assign c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
  end

  assign s  = p ^ c[BLOCK-1:0];
  // A fully propagating group passes ci straight through, cutting the ripple off the chain.
  assign co = (&p) ? ci : c[BLOCK];
endmodule

// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder: GPS skip groups per stage, global-stall valid/ready pipe.
// Define CSA_SUB_EN to add the sub port (a - b with cin forced to 1).
module carry_skip_adder_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4,
  parameter int GPS   = 2
) (
  input logic                     clk,
  input logic                     rst,
  carry_skip_adder_pipe_if.slave  bus
);
  localparam int S = csa_stages(WIDTH, BLOCK, GPS);

  if (!csa_params_ok(WIDTH, BLOCK, GPS)) begin : g_bad_params
    $error("carry_skip_adder_pipe: WIDTH must be a multiple of BLOCK and GPS must be >= 1");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

`ifdef CSA_SUB_EN
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub | bus.cin;
`else
  assign b_eff = bus.b;
  assign c_eff = bus.cin;
`endif

  // Each stage keeps finished sum bits below HI and only the operand bits above it.
  for (genvar k = 0; k < S; k++) begin : g_stg
    localparam int LO = k * GPS * BLOCK;
    localparam int HI = (k == S - 1) ? WIDTH : (k + 1) * GPS * BLOCK;
    localparam int NG = (HI - LO) / BLOCK;

    logic [WIDTH-1:LO] src_a;
    logic [WIDTH-1:LO] src_b;
    logic              src_v;
    logic [HI-1:LO]    gs;
    logic [NG:0]       gc;
    logic [HI-1:0]     sum_d;
    stage_ctl_t        ctl_q;
    logic [HI-1:0]     sum_q;

    if (k == 0) begin : g_head
      assign src_a = bus.a;
      assign src_b = b_eff;
      assign src_v = bus.in_valid;
      assign gc[0] = c_eff;
      assign sum_d = gs;
    end else begin : g_body
      assign src_a = g_stg[k-1].g_ops.opa_q;
      assign src_b = g_stg[k-1].g_ops.opb_q;
      assign src_v = g_stg[k-1].ctl_q.vld;
      assign gc[0] = g_stg[k-1].ctl_q.cy;
      assign sum_d = {gs, g_stg[k-1].sum_q};
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
      carry_skip_group #(.BLOCK(BLOCK)) u_grp (
        .a  (src_a[LO + g*BLOCK +: BLOCK]),
        .b  (src_b[LO + g*BLOCK +: BLOCK]),
        .ci (gc[g]),
        .s  (gs[LO + g*BLOCK +: BLOCK]),
        .co (gc[g+1])
      );
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (advance) begin
        ctl_q <= '{vld: src_v, cy: gc[NG]};
        sum_q <= sum_d;
      end
    end

    if (k < S - 1) begin : g_ops
      logic [WIDTH-1:HI] opa_q;
      logic [WIDTH-1:HI] opb_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (advance) begin
          opa_q <= src_a[WIDTH-1:HI];
          opb_q <= src_b[WIDTH-1:HI];
        end
      end
    end else begin : g_tail
      logic c_msb;
      logic ovf_q;

      // Carry into the MSB recovered from its sum bit and operand bits.
      assign c_msb = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ gs[WIDTH-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= c_msb ^ gc[NG];
        end
      end
    end
  end

  assign bus.out_valid = g_stg[S-1].ctl_q.vld;
  assign bus.sum       = g_stg[S-1].sum_q;
  assign bus.cout      = g_stg[S-1].ctl_q.cy;
  assign bus.ovf       = g_stg[S-1].g_tail.ovf_q;
endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Self-checking bench for carry_skip_adder_pipe (defaults 32/4/2, four stages).
module tb_carry_skip_adder_pipe;
  localparam int W   = 32;
  localparam int LAT = 4;
  localparam int NB  = 1000;

  localparam logic [W-1:0] TV_A [5] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
  localparam logic [W-1:0] TV_B [5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 32'h9ABC_DEF0};
  localparam logic         TV_C [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [W-1:0] TV_S [5] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'hACF1_3568};
  localparam logic         TV_O [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic         TV_V [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  carry_skip_adder_pipe_if #(.WIDTH(W)) bus ();

  carry_skip_adder_pipe #(.WIDTH(W), .BLOCK(4), .GPS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [W+1:0] exp_q [$];

  // {ovf, cout, sum} from plain wide arithmetic and sign rules.
  function automatic logic [W+1:0] ref_calc(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic cv, input logic sv);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         cc;
    logic         ov;
    bb   = sv ? ~bv : bv;
    cc   = sv ? 1'b1 : cv;
    full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, cc};
    ov   = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
    return {ov, full};
  endfunction

  function automatic logic rnd_sub();
`ifdef CSA_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies one cycle of inputs and keeps the reference queue in step with transfers.
  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic sv, input logic ordy);
    bus.in_valid  = v;
    bus.a         = av;
    bus.b         = bv;
    bus.cin       = cv;
`ifdef CSA_SUB_EN
    bus.sub       = sv;
`endif
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (v && bus.in_ready) exp_q.push_back(ref_calc(av, bv, cv, sv));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.sum !== '0) $display("FAIL reset_sum: got %h want 0", bus.sum); else n_pass++;
    n_chk++; if (bus.cout !== 1'b0) $display("FAIL reset_cout: got %0b want 0", bus.cout); else n_pass++;
    n_chk++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", bus.ovf); else n_pass++;
    rst = 1'b0;
    tick();
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, TV_A[i], TV_B[i], TV_C[i], 1'b0, 1'b1);
      tick();
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        lat++;
      end
      n_chk++; if (lat != LAT) $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, LAT); else n_pass++;
      n_chk++; if (bus.sum !== TV_S[i]) $display("FAIL directed%0d_sum: got %h want %h", i, bus.sum, TV_S[i]); else n_pass++;
      n_chk++; if (bus.cout !== TV_O[i]) $display("FAIL directed%0d_cout: got %0b want %0b", i, bus.cout, TV_O[i]); else n_pass++;
      n_chk++; if (bus.ovf !== TV_V[i]) $display("FAIL directed%0d_ovf: got %0b want %0b", i, bus.ovf, TV_V[i]); else n_pass++;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    exp_q.delete();
  endtask

`ifdef CSA_SUB_EN
  task automatic test_sub();
    int lat;
    drive(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
    tick();
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      lat++;
    end
    n_chk++; if (lat != LAT) $display("FAIL sub_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_chk++; if (bus.sum !== 32'hFFFF_FFFE) $display("FAIL sub_sum: got %h want fffffffe", bus.sum); else n_pass++;
    n_chk++; if (bus.cout !== 1'b0) $display("FAIL sub_cout: got %0b want 0", bus.cout); else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    exp_q.delete();
  endtask
`endif

  task automatic test_back_to_back();
    logic ev;
    for (int c = 0; c < NB + LAT + 2; c++) begin
      ev = (c >= LAT) && (c < NB + LAT);
      n_chk++; if (bus.out_valid !== ev) $display("FAIL b2b_valid c=%0d: got %0b want %0b", c, bus.out_valid, ev); else n_pass++;
      if (bus.out_valid) begin
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra c=%0d: got %h with nothing expected", c, bus.sum);
        else if ({bus.ovf, bus.cout, bus.sum} !== exp_q[0])
          $display("FAIL b2b_data c=%0d: got %h want %h", c, {bus.ovf, bus.cout, bus.sum}, exp_q[0]);
        else n_pass++;
      end
      if (c < NB) drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), rnd_sub(), 1'b1);
      else        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    n_chk++; if (exp_q.size() != 0) $display("FAIL b2b_leftover: got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_stall();
    int got;
    for (int i = 0; i < LAT; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), rnd_sub(), 1'b1);
      tick();
    end
    n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL stall_full: got %0b want 1", bus.out_valid); else n_pass++;
    for (int s = 0; s < 6; s++) begin
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
      n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready s=%0d: got %0b want 0", s, bus.in_ready); else n_pass++;
      n_chk++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0 || {bus.ovf, bus.cout, bus.sum} !== exp_q[0])
        $display("FAIL stall_hold s=%0d: got v=%0b %h", s, bus.out_valid, {bus.ovf, bus.cout, bus.sum});
      else n_pass++;
      tick();
    end
    got = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      if (bus.out_valid) begin
        got++;
        n_chk++;
        if (exp_q.size() == 0 || {bus.ovf, bus.cout, bus.sum} !== exp_q[0])
          $display("FAIL stall_drain c=%0d: got %h", c, {bus.ovf, bus.cout, bus.sum});
        else n_pass++;
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    n_chk++; if (got != LAT) $display("FAIL stall_count: got %0d results want %0d", got, LAT); else n_pass++;
  endtask

  task automatic test_random_ready();
    logic iv, ordy;
    int   c;
    for (int i = 0; i < 400; i++) begin
      if (bus.out_valid) begin
        n_chk++;
        if (exp_q.size() == 0 || {bus.ovf, bus.cout, bus.sum} !== exp_q[0])
          $display("FAIL rr_data i=%0d: got %h", i, {bus.ovf, bus.cout, bus.sum});
        else n_pass++;
      end
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      drive(iv, $urandom, $urandom, 1'($urandom_range(0, 1)), rnd_sub(), ordy);
      n_chk++;
      if (bus.in_ready !== (!bus.out_valid || ordy))
        $display("FAIL rr_in_ready i=%0d: got %0b want %0b", i, bus.in_ready, !bus.out_valid || ordy);
      else n_pass++;
      tick();
    end
    c = 0;
    while (exp_q.size() > 0 && c < 30) begin
      if (bus.out_valid) begin
        n_chk++;
        if ({bus.ovf, bus.cout, bus.sum} !== exp_q[0]) $display("FAIL rr_drain c=%0d: got %h want %h", c, {bus.ovf, bus.cout, bus.sum}, exp_q[0]);
        else n_pass++;
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      c++;
    end
    n_chk++; if (exp_q.size() != 0) $display("FAIL rr_leftover: got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_flush();
    int lat;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      tick();
    end
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", bus.out_valid); else n_pass++;
    exp_q.delete();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL flush_stale c=%0d: got %0b want 0", c, bus.out_valid); else n_pass++;
    end
    drive(1'b1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, 1'b1);
    tick();
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      lat++;
    end
    n_chk++; if (lat != LAT) $display("FAIL flush_after_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_chk++; if (bus.sum !== 32'h1010_1011) $display("FAIL flush_after_sum: got %h want 10101011", bus.sum); else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
`ifdef CSA_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    test_stall();
    test_random_ready();
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish within 200000 time units");
    $fatal(1);
  end
endmodule
